pipelined_add_sub: RTL
======================

// Module: pipelined_add_sub
// PURPOSE
//  Parametrised, pipelined adder/subtractor that generalises the 32-bit ripple-of-4-bit-CLA adder.
//  Operands are split into STAGES equal slices, and one slice is resolved per clock.
//  Each slice uses a 4-bit carry-lookahead structure internally.
//  Supports ADD/SUB/ADC/SBC and produces carry, signed-overflow, zero and negative flags.
//  A valid/ready handshake lets it sit between the ALU operand latches and the result register.
// PARAMETERS
//  WIDTH   32  operand/result width; must be a multiple of 4*STAGES
//  STAGES  4   pipeline depth = latency in cycles; slice width SW = WIDTH/STAGES
// PORTS
//  clock      in   1      rising-edge clock
//  clear_n    in   1      asynchronous active-low reset
//  in_valid   in   1      operands/op present on this cycle
//  in_ready   out  1      block accepts an operand set this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  op         in   2      00 ADD a+b; 01 SUB a+~b+1; 10 ADC a+b+cin; 11 SBC a+~b+cin
//  carry_in   in   1      used only by ADC/SBC
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      downstream accepts the result
//  result     out  WIDTH  sum/difference, mod 2^WIDTH
//  carry_out  out  1      carry out of MSB (for SUB/SBC, 1 = no borrow)
//  overflow   out  1      signed overflow
//  zero       out  1      result == 0
//  negative   out  1      result[WIDTH-1]
// BEHAVIOUR
//  Reset (clear_n=0, async):
//   - all stage valid bits, out_valid, result and every flag go to 0.
//   - in_ready follows the advance rule, so it reads 1 immediately.
//  Operand conditioning at input:
//   - b_eff = op[0] ? ~b : b
//   - cin   = op[1] ? carry_in : op[0]
//  Pipeline advance:
//   - advance = out_ready | ~out_valid, and in_ready = advance (combinational).
//   - When advance=1, every stage shifts one step and bubbles move with the data.
//   - When advance=0, all stages hold; no data is lost or duplicated.
//  Accept rule: an operand set is accepted when in_valid & in_ready.
//  Stage k (k = 0..STAGES-1):
//   - adds slice k of a and b_eff plus the carry registered from stage k-1 (cin for k=0).
//   - registers its SW-bit partial sum and carry.
//   - upper, not-yet-used operand slices are delayed alongside the data.
//   - lower, already-computed sum slices are delayed alongside the data.
//  Latency: exactly STAGES cycles from acceptance to out_valid when there is no stall.
//  Throughput: 1 result per clock.
//  Flags are registered with the final stage:
//   - overflow = (a[MSB] == b_eff[MSB]) & (result[MSB] != a[MSB])
//   - zero and negative are computed from the full result.
//  out_valid holds, with result/flags stable, until out_ready=1.
//  Simultaneous accept and drain with the pipe full and out_ready=1: both occur; the pipe stays full.
//  Each flag reflects only its own operand set; there is no cross-transaction carry state.
//  Reset mid-operation discards all in-flight data, and out_valid falls asynchronously.
//  Bubble stages may hold stale data but never raise out_valid.
// TESTING (WIDTH=32, STAGES=4)
//  1. ADD 0x0000_0005 + 0x0000_0003, out_ready=1
//     -> out_valid on cycle 4 after accept; result=0x0000_0008, carry=0, ovf=0, zero=0, neg=0.
//  2. ADD 0xFFFF_FFFF + 0x0000_0001 (carry ripples through all stages)
//     -> result=0, carry_out=1, zero=1, overflow=0.
//  3. SUB 0x7FFF_FFFF - 0xFFFF_FFFF
//     -> result=0x8000_0000, overflow=1, negative=1, carry_out=0.
//     ADC 0x1+0x1 with carry_in=1 -> result=0x3.
//  4. Back-to-back 8 operand sets, out_ready low for cycles 5-7
//     -> in_ready=0 while stalled, results emerge in order with correct values, none dropped or duplicated.
//  5. Assert clear_n=0 with 3 ops in flight
//     -> out_valid=0 and result=0 immediately.
//     After release, a new op returns after 4 cycles with no residue from the old ops.

Source files
------------

// File: rtl/pipelined_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_add_sub
// Purpose  : Parametrised pipelined adder/subtractor. Operands are cut into
//            STAGES slices of SW = WIDTH/STAGES bits. One slice is resolved
//            per clock, and the slice carry is registered between stages.
//            Inside a slice, 4-bit carry-lookahead groups are rippled.
//            Supports ADD/SUB/ADC/SBC. Produces carry, signed-overflow,
//            zero and negative flags. A valid/ready handshake is provided on
//            both the input side and the output side.
// Ports    : clock      - rising-edge clock
//            clear_n    - asynchronous active-low reset
//            in_valid   - operand set present this cycle
//            in_ready   - block accepts an operand set this cycle
//            a, b       - operands (WIDTH bits)
//            op         - 00 ADD, 01 SUB, 10 ADC, 11 SBC
//            carry_in   - carry input, used only by ADC/SBC
//            out_valid  - result and flags valid
//            out_ready  - downstream accepts the result
//            result     - sum/difference mod 2^WIDTH
//            carry_out  - carry out of MSB (for SUB/SBC, 1 = no borrow)
//            overflow   - signed overflow
//            zero       - result == 0
//            negative   - result MSB
// Parameters: WIDTH must be a multiple of 4*STAGES; latency = STAGES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int SW     = WIDTH / STAGES;
    localparam int GROUPS = SW / 4;
    localparam int MSB    = WIDTH - 1;

    // ------------------------------------------------------------------
    // Slice adder: GROUPS rippled 4-bit carry-lookahead groups.
    // The returned value is {carry_out, sum[SW-1:0]}.
    // ------------------------------------------------------------------
    function automatic logic [SW:0] slice_add(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          c
    );
        logic [SW-1:0] s;
        logic [3:0]    g;
        logic [3:0]    p;
        logic [4:0]    cc;
        logic          grp_c;
        s     = '0;
        grp_c = c;
        for (int gi = 0; gi < GROUPS; gi++) begin
            g     = x[gi*4 +: 4] & y[gi*4 +: 4];
            p     = x[gi*4 +: 4] ^ y[gi*4 +: 4];
            cc[0] = grp_c;
            cc[1] = g[0] | (p[0] & cc[0]);
            cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
            cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & cc[0]);
            cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & cc[0]);
            s[gi*4 +: 4] = p ^ cc[3:0];
            grp_c        = cc[4];
        end
        return {grp_c, s};
    endfunction

    // ------------------------------------------------------------------
    // Handshake: the whole pipe moves whenever the output slot is free or
    // being drained, so a full pipe can accept and drain in the same cycle.
    // ------------------------------------------------------------------
    logic w_advance;
    assign w_advance = out_ready | ~out_valid;
    assign in_ready  = w_advance;

    // Operand conditioning ahead of stage 0.
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin;
    assign w_b_eff = op[0] ? ~b : b;
    assign w_cin   = op[1] ? carry_in : op[0];

    // Flag registers, loaded alongside the final stage.
    logic r_ovf_q;
    logic r_zero_q;
    logic r_neg_q;

    // ------------------------------------------------------------------
    // Stage k resolves bits [k*SW +: SW]. Each stage only carries forward
    // the operand bits that later stages still need and the sum bits that
    // earlier stages already produced, so register widths vary per stage.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SW;

        logic [WIDTH-1:LO]    w_a_in;
        logic [WIDTH-1:LO]    w_b_in;
        logic                 w_c_in;
        logic                 w_v_in;
        logic [SW:0]          w_slice;
        logic [LO+SW-1:0]     sum_d;
        logic                 carry_d;

        logic                 valid_q;
        logic                 carry_q;
        logic [LO+SW-1:0]     sum_q;

        if (k == 0) begin : g_first
            assign w_a_in = a;
            assign w_b_in = w_b_eff;
            assign w_c_in = w_cin;
            assign w_v_in = in_valid;
            assign sum_d  = w_slice[SW-1:0];
        end else begin : g_next
            assign w_a_in = g_stage[k-1].g_fwd.opa_q;
            assign w_b_in = g_stage[k-1].g_fwd.opb_q;
            assign w_c_in = g_stage[k-1].carry_q;
            assign w_v_in = g_stage[k-1].valid_q;
            assign sum_d  = {w_slice[SW-1:0], g_stage[k-1].sum_q};
        end

        assign w_slice = slice_add(w_a_in[LO +: SW], w_b_in[LO +: SW], w_c_in);
        assign carry_d = w_slice[SW];

        // Bubbles shift with the data; their payload may be stale but their
        // valid bit is 0, so they never reach out_valid.
        always_ff @(posedge clock or negedge clear_n) begin
            if (!clear_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (w_advance) begin
                valid_q <= w_v_in;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Upper operand slices still to be consumed, including the MSBs
            // needed by the overflow flag at the last stage.
            logic [WIDTH-1:LO+SW] opa_q;
            logic [WIDTH-1:LO+SW] opb_q;

            always_ff @(posedge clock or negedge clear_n) begin
                if (!clear_n) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (w_advance) begin
                    opa_q <= w_a_in[WIDTH-1:LO+SW];
                    opb_q <= w_b_in[WIDTH-1:LO+SW];
                end
            end
        end else begin : g_flags
            // The final stage sees the complete sum, so all flags are
            // computed here and registered with the last slice.
            always_ff @(posedge clock or negedge clear_n) begin
                if (!clear_n) begin
                    r_ovf_q  <= 1'b0;
                    r_zero_q <= 1'b0;
                    r_neg_q  <= 1'b0;
                end else if (w_advance) begin
                    r_ovf_q  <= (w_a_in[MSB] == w_b_in[MSB]) & (sum_d[MSB] != w_a_in[MSB]);
                    r_zero_q <= (sum_d == '0);
                    r_neg_q  <= sum_d[MSB];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign result    = g_stage[STAGES-1].sum_q;
    assign carry_out = g_stage[STAGES-1].carry_q;
    assign overflow  = r_ovf_q;
    assign zero      = r_zero_q;
    assign negative  = r_neg_q;

endmodule
`default_nettype wire
